ex_stage_controller: RTL and testbench

//  Sequences the 16-bit execute stage: decodes the ID-stage opcode into registered EX controls
//  (aluop, aluin1, aluin2) and detects load-use hazards, inserting a stall bubble.

---
 rtl/ex_stage_controller_if.sv | 35 +++
 rtl/ex_stage_controller.sv | 187 ++++++++++++++++++
 tb/tb_ex_stage_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ex_stage_controller_if.sv
// Bundles the decode-side inputs, ALU flags and execute-stage control outputs of the EX stage controller.
interface ex_stage_controller_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [3:0]       id_rs1;
    logic [3:0]       id_rs2;
    logic [3:0]       id_rd;
    logic             zero;
    logic             pos;
    logic             ex_valid;
    logic             aluop;
    logic             aluin1;
    logic [1:0]       aluin2;
    logic [3:0]       ex_rd;
    logic             stall;
    logic             flush;
    logic             pc_sel;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, zero, pos,
        input  ex_valid, aluop, aluin1, aluin2, ex_rd, stall, flush, pc_sel,
               illegal, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, zero, pos,
        output ex_valid, aluop, aluin1, aluin2, ex_rd, stall, flush, pc_sel,
               illegal, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_stage_controller.sv
// Execute-stage controller: registers decoded ALU controls, stalls on load-use hazards,
// and redirects fetch while squashing wrong-path instructions on taken branches/jumps.
module ex_stage_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic rst,
    ex_stage_controller_if.slave bus
);
    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_SW   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BGT  = 4'd6;
    localparam logic [3:0] OP_JAL  = 4'd7;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t           state, next_state;
    logic [FC_W-1:0]  fcount, next_fcount;

    logic             ex_valid_q;
    logic             aluop_q;
    logic             aluin1_q;
    logic [1:0]       aluin2_q;
    logic [3:0]       ex_rd_q;
    logic [3:0]       ex_opcode_q;
    logic             ex_is_load_q;
    logic             illegal_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             dec_valid, dec_aluop, dec_aluin1, dec_load, dec_illegal;
    logic [1:0]       dec_aluin2;
    logic [3:0]       dec_rd;
    logic             hazard, taken, accept;
    logic             stall_c, flush_c, pc_sel_c;

    always_comb begin
        dec_valid   = 1'b0;
        dec_aluop   = 1'b0;
        dec_aluin1  = 1'b0;
        dec_aluin2  = 2'd0;
        dec_rd      = 4'd0;
        dec_load    = 1'b0;
        dec_illegal = 1'b0;
        if (bus.id_valid) begin
            if (bus.id_opcode[3]) begin
                dec_illegal = 1'b1;
            end else begin
                dec_valid  = 1'b1;
                dec_aluin1 = 1'b1;
                dec_rd     = bus.id_rd;
                case (bus.id_opcode)
                    OP_SUB:  dec_aluop = 1'b1;
                    OP_ADDI: dec_aluin2 = 2'd2;
                    OP_LW: begin
                        dec_aluin2 = 2'd2;
                        dec_load   = 1'b1;
                    end
                    OP_SW: begin
                        dec_aluin2 = 2'd2;
                        dec_rd     = 4'd0;
                    end
                    OP_BEQ, OP_BGT: begin
                        dec_aluop = 1'b1;
                        dec_rd    = 4'd0;
                    end
                    OP_JAL: begin
                        dec_aluin1 = 1'b0;
                        dec_aluin2 = 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bubbles carry opcode 0 and ex_rd 0, so neither term can fire on an empty EX slot.
    assign hazard = ex_valid_q && ex_is_load_q && (ex_rd_q != 4'd0) && bus.id_valid &&
                    ((bus.id_rs1 == ex_rd_q) || (bus.id_rs2 == ex_rd_q));
    assign taken  = ex_valid_q && ((ex_opcode_q == OP_JAL) ||
                    ((ex_opcode_q == OP_BEQ) && bus.zero) ||
                    ((ex_opcode_q == OP_BGT) && bus.pos));

    always_comb begin
        next_state  = state;
        next_fcount = fcount;
        stall_c     = 1'b0;
        flush_c     = 1'b0;
        pc_sel_c    = 1'b0;
        accept      = 1'b0;
        case (state)
            RUN: begin
                if (taken) begin
                    flush_c  = 1'b1;
                    pc_sel_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        next_state  = FLUSH;
                        next_fcount = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (hazard) begin
                    stall_c    = 1'b1;
                    next_state = STALL;
                end else begin
                    accept = 1'b1;
                end
            end
            STALL: begin
                accept     = 1'b1;
                next_state = RUN;
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (fcount <= FC_W'(1)) begin
                    next_state  = RUN;
                    next_fcount = '0;
                end else begin
                    next_fcount = fcount - FC_W'(1);
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            fcount       <= '0;
            ex_valid_q   <= 1'b0;
            aluop_q      <= 1'b0;
            aluin1_q     <= 1'b0;
            aluin2_q     <= 2'd0;
            ex_rd_q      <= 4'd0;
            ex_opcode_q  <= 4'd0;
            ex_is_load_q <= 1'b0;
            illegal_q    <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state  <= next_state;
            fcount <= next_fcount;
            if (accept && dec_valid) begin
                ex_valid_q   <= 1'b1;
                aluop_q      <= dec_aluop;
                aluin1_q     <= dec_aluin1;
                aluin2_q     <= dec_aluin2;
                ex_rd_q      <= dec_rd;
                ex_opcode_q  <= bus.id_opcode;
                ex_is_load_q <= dec_load;
            end else begin
                ex_valid_q   <= 1'b0;
                aluop_q      <= 1'b0;
                aluin1_q     <= 1'b0;
                aluin2_q     <= 2'd0;
                ex_rd_q      <= 4'd0;
                ex_opcode_q  <= 4'd0;
                ex_is_load_q <= 1'b0;
            end
            if (accept && dec_illegal) begin
                illegal_q <= 1'b1;
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (taken && (state == RUN) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.aluop     = aluop_q;
    assign bus.aluin1    = aluin1_q;
    assign bus.aluin2    = aluin2_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.stall     = stall_c;
    assign bus.flush     = flush_c;
    assign bus.pc_sel    = pc_sel_c;
    assign bus.illegal   = illegal_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_ex_stage_controller.sv
// Directed bench for ex_stage_controller: each cycle's expected outputs are queued by the
// stimulus process and checked at the following negedge by an independent monitor.
module tb_ex_stage_controller;
    localparam int CNT_W = 16;

    typedef struct {
        logic             ev;
        logic             aop;
        logic             in1;
        logic [1:0]       in2;
        logic [3:0]       rd;
        logic             st;
        logic             fl;
        logic             pc;
        logic             ill;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    ex_stage_controller_if #(.CNT_W(CNT_W)) bus ();

    ex_stage_controller #(
        .FLUSH_CYCLES(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic exp_t mk(input logic ev, input logic aop, input logic in1,
                                input logic [1:0] in2, input logic [3:0] rd, input logic st,
                                input logic fl, input logic pc, input logic ill,
                                input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
        exp_t e;
        e.ev = ev; e.aop = aop; e.in1 = in1; e.in2 = in2; e.rd = rd;
        e.st = st; e.fl = fl; e.pc = pc; e.ill = ill; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    task automatic apply_stimulus(input logic r, input logic v, input logic [3:0] op,
                                  input logic [3:0] rs1, input logic [3:0] rs2,
                                  input logic [3:0] rd, input logic z, input logic p,
                                  input bit chk, input exp_t e);
        @(posedge clk);
        #1;
        rst           = r;
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        bus.zero      = z;
        bus.pos       = p;
        if (chk) exp_q.push_back(e);
    endtask

    task automatic check_output(input int cyc, input string name,
                                input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL vec%0d %s actual=%0h expected=%0h", cyc, name, act, req);
        end
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(n, "ex_valid",  CNT_W'(bus.ex_valid), CNT_W'(e.ev));
                check_output(n, "aluop",     CNT_W'(bus.aluop),    CNT_W'(e.aop));
                check_output(n, "aluin1",    CNT_W'(bus.aluin1),   CNT_W'(e.in1));
                check_output(n, "aluin2",    CNT_W'(bus.aluin2),   CNT_W'(e.in2));
                check_output(n, "ex_rd",     CNT_W'(bus.ex_rd),    CNT_W'(e.rd));
                check_output(n, "stall",     CNT_W'(bus.stall),    CNT_W'(e.st));
                check_output(n, "flush",     CNT_W'(bus.flush),    CNT_W'(e.fl));
                check_output(n, "pc_sel",    CNT_W'(bus.pc_sel),   CNT_W'(e.pc));
                check_output(n, "illegal",   CNT_W'(bus.illegal),  CNT_W'(e.ill));
                check_output(n, "stall_cnt", bus.stall_cnt,        e.sc);
                check_output(n, "flush_cnt", bus.flush_cnt,        e.fc);
                n++;
            end
        end
    end

    initial begin
        bus.id_valid = 1'b0; bus.id_opcode = 4'd0; bus.id_rs1 = 4'd0;
        bus.id_rs2 = 4'd0; bus.id_rd = 4'd0; bus.zero = 1'b0; bus.pos = 1'b0;
        $display("[TB] start");
        // reset held two cycles, then idle
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        // ADD r3, ADDI r4, LW r5, SUB rs2=r5 (load-use stall, held one cycle)
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        apply_stimulus(0, 1, 2, 1, 0, 4, 0, 0, 1, mk(1,0,1,0,3, 0,0,0,0, 0,0));
        apply_stimulus(0, 1, 3, 1, 0, 5, 0, 0, 1, mk(1,0,1,2,4, 0,0,0,0, 0,0));
        apply_stimulus(0, 1, 1, 2, 5, 6, 0, 0, 1, mk(1,0,1,2,5, 1,0,0,0, 0,0));
        apply_stimulus(0, 1, 1, 2, 5, 6, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 1,0));
        // BEQ taken with zero=1, wrong-path ADDs squashed for two flush cycles
        apply_stimulus(0, 1, 5, 1, 2, 7, 0, 0, 1, mk(1,1,1,0,6, 0,0,0,0, 1,0));
        apply_stimulus(0, 1, 0, 1, 2, 8, 1, 0, 1, mk(1,1,1,0,0, 0,1,1,0, 1,0));
        apply_stimulus(0, 1, 0, 1, 2, 9, 1, 0, 1, mk(0,0,0,0,0, 0,1,0,0, 1,1));
        // BEQ not taken with zero=0
        apply_stimulus(0, 1, 5, 3, 4, 0, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 1,1));
        apply_stimulus(0, 1, 3, 1, 0, 5, 0, 0, 1, mk(1,1,1,0,0, 0,0,0,0, 1,1));
        // JAL r5 taken; following SUB reads r5 but is flushed, no stall
        apply_stimulus(0, 1, 7, 0, 0, 5, 0, 0, 1, mk(1,0,1,2,5, 0,0,0,0, 1,1));
        apply_stimulus(0, 1, 1, 5, 1, 2, 0, 0, 1, mk(1,0,0,1,5, 0,1,1,0, 1,1));
        apply_stimulus(0, 1, 1, 5, 1, 2, 0, 0, 1, mk(0,0,0,0,0, 0,1,0,0, 1,2));
        // BGT taken with pos=1, then illegal opcode 9 accepted
        apply_stimulus(0, 1, 6, 1, 2, 3, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 1,2));
        apply_stimulus(0, 1, 9, 1, 2, 4, 0, 1, 1, mk(1,1,1,0,0, 0,1,1,0, 1,2));
        apply_stimulus(0, 1, 9, 1, 2, 4, 0, 1, 1, mk(0,0,0,0,0, 0,1,0,0, 1,3));
        apply_stimulus(0, 1, 9, 1, 2, 4, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 1,3));
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,1, 1,3));
        apply_stimulus(0, 1, 7, 0, 0, 2, 0, 0, 1, mk(1,0,1,0,3, 0,0,0,1, 1,3));
        apply_stimulus(0, 1, 0, 1, 2, 3, 0, 0, 1, mk(1,0,0,1,2, 0,1,1,1, 1,3));
        // reset asserted during FLUSH
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0, 0,1,0,1, 1,4));
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        // LW r0 followed by reader of r0: no hazard; then SW writes no register
        apply_stimulus(0, 1, 3, 1, 0, 0, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        apply_stimulus(0, 1, 0, 0, 0, 1, 0, 0, 1, mk(1,0,1,2,0, 0,0,0,0, 0,0));
        apply_stimulus(0, 1, 4, 1, 2, 6, 0, 0, 1, mk(1,0,1,0,1, 0,0,0,0, 0,0));
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, mk(1,0,1,2,0, 0,0,0,0, 0,0));
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0,0,0,0,0, 0,0,0,0, 0,0));
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("[TB] FAIL timeout actual=running expected=done");
            $fatal(1, "[TB] timeout");
        end
    end
endmodule
